// File: rtl/mode_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mode_sequencer_pkg                                                   |
// | State codes, operation encodings and mode decode for mode_sequencer. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package mode_sequencer_pkg;

    localparam logic [3:0] c_ST_IDLE    = 4'd0;
    localparam logic [3:0] c_ST_INPUT   = 4'd1;
    localparam logic [3:0] c_ST_GEN     = 4'd2;
    localparam logic [3:0] c_ST_DISPLAY = 4'd3;
    localparam logic [3:0] c_ST_OP_SEL  = 4'd4;
    localparam logic [3:0] c_ST_SEL_A   = 4'd5;
    localparam logic [3:0] c_ST_SEL_B   = 4'd6;
    localparam logic [3:0] c_ST_CHECK   = 4'd7;
    localparam logic [3:0] c_ST_ERROR   = 4'd8;
    localparam logic [3:0] c_ST_CALC    = 4'd9;
    localparam logic [3:0] c_ST_RESULT  = 4'd10;
    localparam logic [3:0] c_ST_DONE    = 4'd11;

    localparam logic [2:0] c_OP_TRANSPOSE = 3'd0;
    localparam logic [2:0] c_OP_ADD       = 3'd1;
    localparam logic [2:0] c_OP_SCALAR    = 3'd2;
    localparam logic [2:0] c_OP_MUL       = 3'd3;
    localparam logic [2:0] c_OP_CONV      = 3'd4;

    function automatic logic [3:0] mode_target(input logic [1:0] mode);
        case (mode)
            2'b00:   return c_ST_INPUT;
            2'b01:   return c_ST_GEN;
            2'b10:   return c_ST_DISPLAY;
            default: return c_ST_OP_SEL;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mode_sequencer_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | btn_debounce                                                         |
// | Stability-window debouncer with a registered rising-edge press pulse.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module btn_debounce #(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_press
);
    localparam int c_CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEB_CYCLES - 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_level;
    logic               r_press;

    // r_cnt counts consecutive samples that disagree with the debounced level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_press <= 1'b0;
            if (i_btn == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_cnt   <= '0;
                r_level <= i_btn;
                r_press <= i_btn;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_press = r_press;

endmodule
`default_nettype wire

// File: rtl/mode_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mode_sequencer                                                       |
// | Button-driven sequencer for matrix load/generate/display/calculate.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mode_sequencer
    import mode_sequencer_pkg::*;
#(
    parameter int SW_W       = 8,
    parameter int OP_W       = 3,
    parameter int IDX_W      = 2,
    parameter int DEB_CYCLES = 1_000_000,
    parameter int ERR_CYCLES = 100_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SW_W-1:0]  sw,
    input  logic             btn_confirm,
    input  logic             btn_back,
    input  logic             rx_done,
    input  logic             rx_error,
    input  logic             gen_done,
    input  logic             disp_done,
    input  logic             calc_done,
    input  logic             operand_ok,
    output logic [3:0]       state,
    output logic             en_input,
    output logic             start_gen,
    output logic             start_disp,
    output logic             start_calc,
    output logic [OP_W-1:0]  op_code,
    output logic [IDX_W-1:0] idx_a,
    output logic [IDX_W-1:0] idx_b,
    output logic [7:0]       led
);
    localparam int c_ERR_W = $clog2(ERR_CYCLES + 1);
    localparam logic [c_ERR_W-1:0] c_ERR_LOAD = c_ERR_W'(ERR_CYCLES - 1);

    logic [3:0]         r_state;
    logic [3:0]         r_ret;
    logic [c_ERR_W-1:0] r_err_cnt;
    logic               w_confirm;
    logic               w_back;
    logic [3:0]         w_next;
    logic [3:0]         w_ret_next;
    logic               w_latch_op;
    logic               w_latch_a;
    logic               w_latch_b;
    logic               w_unused_sw;

    assign w_unused_sw = ^sw;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_confirm (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (btn_confirm),
        .o_press (w_confirm)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_back (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (btn_back),
        .o_press (w_back)
    );

    // Each branch tests subsystem flags first, then back, then confirm
    always_comb begin
        w_next     = r_state;
        w_ret_next = r_ret;
        w_latch_op = 1'b0;
        w_latch_a  = 1'b0;
        w_latch_b  = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_back)         w_next = c_ST_IDLE;
                else if (w_confirm) w_next = mode_target(sw[SW_W-1 -: 2]);
            end
            c_ST_INPUT: begin
                if (rx_error) begin
                    w_next     = c_ST_ERROR;
                    w_ret_next = c_ST_IDLE;
                end else if (rx_done || w_back) begin
                    w_next = c_ST_IDLE;
                end
            end
            c_ST_GEN:     if (gen_done || w_back)  w_next = c_ST_IDLE;
            c_ST_DISPLAY: if (disp_done || w_back) w_next = c_ST_IDLE;
            c_ST_OP_SEL: begin
                if (w_back) begin
                    w_next = c_ST_IDLE;
                end else if (w_confirm) begin
                    w_latch_op = 1'b1;
                    w_next     = c_ST_SEL_A;
                end
            end
            c_ST_SEL_A: begin
                if (w_back) begin
                    w_next = c_ST_IDLE;
                end else if (w_confirm) begin
                    w_latch_a = 1'b1;
                    w_next    = (op_code == OP_W'(c_OP_TRANSPOSE)) ? c_ST_CHECK : c_ST_SEL_B;
                end
            end
            c_ST_SEL_B: begin
                if (w_back) begin
                    w_next = c_ST_IDLE;
                end else if (w_confirm) begin
                    w_latch_b = 1'b1;
                    w_next    = c_ST_CHECK;
                end
            end
            c_ST_CHECK: begin
                if (operand_ok) begin
                    w_next = c_ST_CALC;
                end else begin
                    w_next     = c_ST_ERROR;
                    w_ret_next = c_ST_SEL_A;
                end
            end
            c_ST_ERROR:  if (w_confirm || r_err_cnt == '0) w_next = r_ret;
            c_ST_CALC:   if (calc_done) w_next = c_ST_RESULT;
            c_ST_RESULT: if (disp_done) w_next = c_ST_DONE;
            c_ST_DONE: begin
                if (w_back)         w_next = c_ST_IDLE;
                else if (w_confirm) w_next = sw[SW_W-1] ? c_ST_OP_SEL : c_ST_IDLE;
            end
            default: w_next = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_ret      <= c_ST_IDLE;
            r_err_cnt  <= '0;
            en_input   <= 1'b0;
            start_gen  <= 1'b0;
            start_disp <= 1'b0;
            start_calc <= 1'b0;
            led        <= 8'h00;
            op_code    <= '0;
            idx_a      <= '0;
            idx_b      <= '0;
        end else begin
            r_state <= w_next;
            r_ret   <= w_ret_next;
            if (w_next == c_ST_ERROR && r_state != c_ST_ERROR)
                r_err_cnt <= c_ERR_LOAD;
            else if (r_state == c_ST_ERROR && r_err_cnt != '0)
                r_err_cnt <= r_err_cnt - 1'b1;
            // Outputs are computed from the next state so they line up with it
            en_input   <= (w_next == c_ST_INPUT);
            start_gen  <= (w_next == c_ST_GEN) && (r_state != c_ST_GEN);
            start_disp <= ((w_next == c_ST_DISPLAY) && (r_state != c_ST_DISPLAY)) ||
                          ((w_next == c_ST_RESULT) && (r_state != c_ST_RESULT));
            start_calc <= (w_next == c_ST_CALC) && (r_state != c_ST_CALC);
            led        <= (w_next == c_ST_ERROR) ? 8'hFF : 8'h00;
            if (w_latch_op) op_code <= sw[OP_W-1:0];
            if (w_latch_a)  idx_a   <= sw[IDX_W-1:0];
            if (w_latch_b)  idx_b   <= sw[IDX_W-1:0];
        end
    end

    assign state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mode_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mode_sequencer                                                    |
// | Directed and random stimulus against a cycle-level reference model.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_mode_sequencer;
    localparam int DEB = 4;
    localparam int ERR = 50;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] sw = 8'h00;
    logic       btn_confirm = 1'b0, btn_back = 1'b0;
    logic       rx_done = 1'b0, rx_error = 1'b0, gen_done = 1'b0;
    logic       disp_done = 1'b0, calc_done = 1'b0, operand_ok = 1'b0;
    logic [3:0] state;
    logic       en_input, start_gen, start_disp, start_calc;
    logic [2:0] op_code;
    logic [1:0] idx_a, idx_b;
    logic [7:0] led;

    mode_sequencer #(
        .SW_W(8), .OP_W(3), .IDX_W(2), .DEB_CYCLES(DEB), .ERR_CYCLES(ERR)
    ) dut (
        .clk(clk), .rst(rst), .sw(sw),
        .btn_confirm(btn_confirm), .btn_back(btn_back),
        .rx_done(rx_done), .rx_error(rx_error), .gen_done(gen_done),
        .disp_done(disp_done), .calc_done(calc_done), .operand_ok(operand_ok),
        .state(state), .en_input(en_input), .start_gen(start_gen),
        .start_disp(start_disp), .start_calc(start_calc), .op_code(op_code),
        .idx_a(idx_a), .idx_b(idx_b), .led(led)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;
    int n_sc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp_v, $time);
    endtask

    // Reference model: state named by its code, buttons by their sample history
    int             m_state, m_prev, m_ret, m_age;
    logic [2:0]     m_op;
    logic [1:0]     m_a, m_b;
    logic [DEB-1:0] m_hist[2];
    int             m_seen[2];
    bit             m_lvl[2], m_press[2];

    task automatic model_reset();
        m_state = 0; m_prev = 0; m_ret = 0; m_age = 0;
        m_op = 0; m_a = 0; m_b = 0;
        for (int b = 0; b < 2; b++) begin
            m_hist[b] = '0; m_seen[b] = 0; m_lvl[b] = 0; m_press[b] = 0;
        end
    endtask

    task automatic deb(input int b, input bit raw);
        m_hist[b] = {m_hist[b][DEB-2:0], raw};
        if (m_seen[b] < DEB) m_seen[b]++;
        m_press[b] = 0;
        if (m_seen[b] == DEB && m_hist[b] == {DEB{~m_lvl[b]}}) begin
            m_lvl[b]   = ~m_lvl[b];
            m_press[b] = m_lvl[b];
        end
    endtask

    task automatic model_update();
        bit cf, bk;
        int nx;
        cf = m_press[0];
        bk = m_press[1];
        nx = m_state;
        case (m_state)
            0:  if (bk) nx = 0; else if (cf) nx = 1 + int'(sw[7:6]);
            1:  if (rx_error) begin nx = 8; m_ret = 0; end
                else if (rx_done || bk) nx = 0;
            2:  if (gen_done || bk) nx = 0;
            3:  if (disp_done || bk) nx = 0;
            4:  if (bk) nx = 0; else if (cf) begin m_op = sw[2:0]; nx = 5; end
            5:  if (bk) nx = 0; else if (cf) begin m_a = sw[1:0]; nx = (m_op == 0) ? 7 : 6; end
            6:  if (bk) nx = 0; else if (cf) begin m_b = sw[1:0]; nx = 7; end
            7:  if (operand_ok) nx = 9; else begin nx = 8; m_ret = 5; end
            8:  begin m_age++; if (cf || m_age >= ERR) nx = m_ret; end
            9:  if (calc_done) nx = 10;
            10: if (disp_done) nx = 11;
            11: if (bk) nx = 0; else if (cf) nx = sw[7] ? 4 : 0;
            default: nx = 0;
        endcase
        if (nx == 8 && m_state != 8) m_age = 0;
        m_prev  = m_state;
        m_state = nx;
        deb(0, btn_confirm);
        deb(1, btn_back);
    endtask

    function automatic logic [18:0] dut_outs();
        return {en_input, start_gen, start_disp, start_calc, led, op_code, idx_a, idx_b};
    endfunction

    function automatic logic [18:0] exp_outs();
        logic sg, sd, sc;
        sg = (m_state == 2 && m_prev != 2);
        sd = (m_state == 3 && m_prev != 3) || (m_state == 10 && m_prev != 10);
        sc = (m_state == 9 && m_prev != 9);
        return {(m_state == 1), sg, sd, sc, ((m_state == 8) ? 8'hFF : 8'h00), m_op, m_a, m_b};
    endfunction

    task automatic step();
        @(posedge clk);
        if (rst) model_reset(); else model_update();
        #1;
        check("state", 32'(state), 32'(m_state));
        check("outs", 32'(dut_outs()), 32'(exp_outs()));
        if (start_calc) n_sc++;
    endtask

    task automatic press(input bit back);
        if (back) btn_back = 1'b1; else btn_confirm = 1'b1;
        repeat (DEB) step();
        btn_back = 1'b0;
        btn_confirm = 1'b0;
        repeat (DEB + 1) step();
    endtask

    initial begin
        int guard, n_led, sc0, hold_c, hold_b;
        model_reset();
        repeat (3) step();
        check("rst_state", 32'(state), 32'd0);
        check("rst_outs", 32'(dut_outs()), 32'd0);
        rst = 1'b0;
        step();

        // Calculation path: OP_SEL, MUL, slots 1 and 2, operands fine
        sw = 8'hC0; press(0);
        check("to_opsel", 32'(state), 32'd4);
        sw = 8'h03; press(0);
        check("op_latch", 32'(op_code), 32'd3);
        check("to_sel_a", 32'(state), 32'd5);
        sw = 8'h01; press(0);
        check("idx_a", 32'(idx_a), 32'd1);
        check("to_sel_b", 32'(state), 32'd6);
        operand_ok = 1'b1; sc0 = n_sc;
        sw = 8'h02; press(0);
        check("idx_b", 32'(idx_b), 32'd2);
        check("to_calc", 32'(state), 32'd9);
        check("calc_pulses", 32'(n_sc - sc0), 32'd1);
        calc_done = 1'b1; step(); calc_done = 1'b0; step();
        check("to_result", 32'(state), 32'd10);
        disp_done = 1'b1; step(); disp_done = 1'b0; step();
        check("to_done", 32'(state), 32'd11);
        sw = 8'h00; press(0);
        check("done_idle", 32'(state), 32'd0);

        // INPUT with simultaneous rx flags, then full error hold
        press(0);
        check("en_input", 32'(en_input), 32'd1);
        rx_error = 1'b1; rx_done = 1'b1; step(); rx_error = 1'b0; rx_done = 1'b0;
        check("rx_err", 32'(state), 32'd8);
        n_led = 0; guard = 0;
        while (state == 4'd8 && guard < 100) begin
            if (led == 8'hFF) n_led++;
            step();
            guard++;
        end
        check("err_hold", 32'(n_led), 32'd50);
        check("err_exit", 32'(state), 32'd0);

        // Failed operand check, early exit on confirm
        sw = 8'hC0; press(0);
        sw = 8'h01; press(0);
        press(0);
        operand_ok = 1'b0; press(0);
        check("chk_err", 32'(state), 32'd8);
        repeat (10) step();
        press(0);
        check("err_confirm", 32'(state), 32'd5);

        // Short glitch must not register
        btn_confirm = 1'b1; repeat (3) step(); btn_confirm = 1'b0;
        repeat (6) step();
        check("glitch", 32'(state), 32'd5);
        press(0);
        check("glitch_sel_b", 32'(state), 32'd6);
        press(1);
        check("back_sel_b", 32'(state), 32'd0);

        // Transpose skips SEL_B; reset asserted mid-CALC
        sw = 8'hC0; press(0);
        sw = 8'h00; press(0);
        operand_ok = 1'b1; sw = 8'h03; press(0);
        check("transpose_calc", 32'(state), 32'd9);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_state", 32'(state), 32'd0);
        check("async_outs", 32'(dut_outs()), 32'd0);
        model_reset();
        repeat (2) step();
        rst = 1'b0;

        // Random phase
        hold_c = 0; hold_b = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold_c == 0) begin btn_confirm = ~btn_confirm; hold_c = $urandom_range(1, 8); end
            if (hold_b == 0) begin btn_back = ~btn_back; hold_b = $urandom_range(2, 14); end
            hold_c--; hold_b--;
            sw         = 8'($urandom);
            rx_done    = ($urandom_range(0, 9) == 0);
            rx_error   = ($urandom_range(0, 15) == 0);
            gen_done   = ($urandom_range(0, 9) == 0);
            disp_done  = ($urandom_range(0, 9) == 0);
            calc_done  = ($urandom_range(0, 9) == 0);
            operand_ok = $urandom_range(0, 1) == 1;
            rst        = ($urandom_range(0, 799) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
